// File: rtl/ram_ready_in_pio.sv
// Avalon-MM input PIO that reports RAM-controller status to the CPU.
// Synchronizes in_port, captures edges into a write-1-to-clear register and raises a masked level irq.
module ram_ready_in_pio #(
    parameter int   WIDTH       = 1,
    parameter int   EDGE_TYPE   = 0,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_mux;
    logic             wr_en;
    logic             rd_en;

    // Bus handshake: a transfer is accepted whenever chipselect is high with its strobe low;
    // there is no waitrequest, reads return on the next clock.
    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync2 & ~prev;
            1:       edge_det = ~sync2 & prev;
            default: edge_det = sync2 ^ prev;
        endcase
    end

    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = sync2;
            ADDR_IRQMASK: rd_mux = irq_mask;
            ADDR_EDGECAP: rd_mux = edge_cap;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1    <= {WIDTH{RESET_LEVEL}};
            sync2    <= {WIDTH{RESET_LEVEL}};
            prev     <= {WIDTH{RESET_LEVEL}};
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
            if (wr_en && address == ADDR_IRQMASK)
                irq_mask <= writedata;
            // A new edge overrides a simultaneous clear so no event is lost.
            edge_cap <= (edge_cap & ~cap_clr) | edge_det;
            irq      <= |(edge_cap & irq_mask);
            if (rd_en)
                readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ram_ready_in_pio.sv
// Bench for ram_ready_in_pio: rising, falling and any-edge instances share one bus and in_port,
// a reference model predicts readdata/irq, and a monitor checks them against a scoreboard queue.
module tb_ram_ready_in_pio;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         read_n = 1'b1;
  logic         write_n = 1'b1;
  logic [W-1:0] writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] rd_r, rd_f, rd_a;
  logic         irq_r, irq_f, irq_a;

  int n_tests = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  ram_ready_in_pio #(.WIDTH(W), .EDGE_TYPE(0), .RESET_LEVEL(1'b0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_r), .irq(irq_r), .in_port(in_port));
  ram_ready_in_pio #(.WIDTH(W), .EDGE_TYPE(1), .RESET_LEVEL(1'b0)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_f), .irq(irq_f), .in_port(in_port));
  ram_ready_in_pio #(.WIDTH(W), .EDGE_TYPE(2), .RESET_LEVEL(1'b0)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_a), .irq(irq_a), .in_port(in_port));

  // reference model: history of sampled in_port levels, newest first
  logic [W-1:0]   smp[$] = '{8'h00, 8'h00, 8'h00};
  logic [W-1:0]   m_cap[3] = '{default: '0};
  logic [W-1:0]   m_rd[3] = '{default: '0};
  logic [2:0]     m_irq = '0;
  logic [W-1:0]   m_mask = '0;
  logic           rd_done = 1'b0;
  logic [3*W-1:0] exp_q[$];

  always @(posedge clk) begin : model
    logic         wr, rd;
    logic [W-1:0] lvl, old_lvl, ev, clr, rv;
    rd_done = 1'b0;
    if (!reset_n) begin
      smp = '{8'h00, 8'h00, 8'h00};
      for (int t = 0; t < 3; t++) begin
        m_cap[t] = '0;
        m_rd[t] = '0;
      end
      m_irq = '0;
      m_mask = '0;
    end else begin
      wr = chipselect && !write_n;
      rd = chipselect && !read_n;
      lvl = smp[1];
      old_lvl = smp[2];
      clr = (wr && address == 2'd3) ? writedata : '0;
      for (int t = 0; t < 3; t++) begin
        ev = (t == 0) ? (lvl & ~old_lvl) : (t == 1) ? (~lvl & old_lvl) : (lvl ^ old_lvl);
        rv = (address == 2'd0) ? lvl : (address == 2'd2) ? m_mask :
             (address == 2'd3) ? m_cap[t] : '0;
        if (rd) m_rd[t] = rv;
        m_irq[t] = |(m_cap[t] & m_mask);
        m_cap[t] = (m_cap[t] & ~clr) | ev;
      end
      if (wr && address == 2'd2) m_mask = writedata;
      if (rd) begin
        exp_q.push_back({m_rd[2], m_rd[1], m_rd[0]});
        rd_done = 1'b1;
      end
      smp = '{in_port, smp[0], smp[1]};
    end
  end

  task automatic check(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [3*W-1:0] e;
    check("irq", {{(3*W-3){1'b0}}, irq_a, irq_f, irq_r}, {{(3*W-3){1'b0}}, m_irq});
    if (rd_done) begin
      if (exp_q.size() == 0) begin
        check("rd_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("readdata", {rd_a, rd_f, rd_r}, e);
      end
    end else begin
      check("rd_hold", {rd_a, rd_f, rd_r}, {m_rd[2], m_rd[1], m_rd[0]});
    end
  end

  // driver tasks
  task automatic bus(input logic wr, input logic rd, input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n = !wr;
    read_n = !rd;
    address = a;
    writedata = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
    read_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [W-1:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    check("reset_readdata", {rd_a, rd_f, rd_r}, '0);
    check("reset_irq", {{(3*W-3){1'b0}}, irq_a, irq_f, irq_r}, '0);
    reset_n = 1'b1;
  endtask

  initial begin
    // reset with input already high: rising edge captured after release
    in_port = 8'h01;
    do_reset(3);
    idle(4);
    bus(0, 1, 2'd0, '0);
    bus(0, 1, 2'd3, '0);

    // latency / mask / irq
    bus(1, 0, 2'd2, 8'hFF);
    set_in(8'h03);
    idle(6);
    bus(0, 1, 2'd3, '0);
    bus(1, 0, 2'd3, 8'h00);
    bus(0, 1, 2'd3, '0);
    bus(1, 0, 2'd3, 8'hFF);
    idle(2);
    bus(0, 1, 2'd3, '0);

    // clear collides with a newly detected edge
    @(negedge clk);
    in_port = 8'h07;
    @(negedge clk);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 8'hFF;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    idle(2);
    bus(0, 1, 2'd3, '0);

    // mask gating, falling pulse
    bus(1, 0, 2'd2, 8'h00);
    set_in(8'h00);
    idle(5);
    bus(1, 0, 2'd2, 8'h0F);
    idle(2);
    bus(0, 1, 2'd2, '0);

    // reserved / read-only addresses
    bus(1, 0, 2'd0, 8'hFF);
    bus(1, 0, 2'd1, 8'hFF);
    bus(0, 1, 2'd1, '0);
    bus(0, 1, 2'd0, '0);
    bus(1, 1, 2'd2, 8'h5A);
    bus(0, 1, 2'd2, '0);

    // reset mid-capture
    set_in(8'hF0);
    idle(3);
    do_reset(1);
    idle(2);
    bus(0, 1, 2'd3, '0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: set_in(W'($urandom));
        3:       idle($urandom_range(1, 4));
        4, 5, 6: bus(0, 1, 2'($urandom_range(0, 3)), '0);
        7:       bus(1, 0, 2'($urandom_range(0, 3)), W'($urandom));
        8:       bus(1, 1, 2'($urandom_range(2, 3)), W'($urandom));
        default: if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 3));
                 else set_in(in_port ^ W'(1 << $urandom_range(0, W-1)));
      endcase
    end
    idle(4);
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
